// File: rtl/ysyx_040066_booth_pp_gen_if.sv
// Operand/result handshake bundle for the radix-4 Booth partial-product generator.
// slave: the generator side; master: the requester/consumer side.
interface ysyx_040066_booth_pp_gen_if;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   src1;
   logic [63:0]   src2;
   logic          a_signed;
   logic          b_signed;
   logic          mulw;
   logic          sel_hi;
   logic          out_valid;
   logic          out_ready;
   logic [4223:0] pp_cols;
   logic          out_sel_hi;
   logic          out_mulw;

   modport slave (
      input  flush, in_valid, src1, src2, a_signed, b_signed, mulw, sel_hi, out_ready,
      output in_ready, out_valid, pp_cols, out_sel_hi, out_mulw
   );

   modport master (
      output flush, in_valid, src1, src2, a_signed, b_signed, mulw, sel_hi, out_ready,
      input  in_ready, out_valid, pp_cols, out_sel_hi, out_mulw
   );
endinterface

// File: rtl/ysyx_040066_booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 33 exact partial products transposed into 128 columns.
// Optional macro YSYX_040066_BOOTH_IN_REG_EN adds an operand register stage (latency 2 instead of 1).
module ysyx_040066_booth_pp_gen (
   input  logic                         clk,
   input  logic                         rst_n,
   ysyx_040066_booth_pp_gen_if.slave    bus
);
   localparam int XLEN = 64;
   localparam int NPP  = (XLEN + 2) / 2;
   localparam int PW   = 2 * XLEN;
   localparam int AW   = XLEN + 2;

   // Magnitude select plus full two's-complement negation for one Booth digit.
   function automatic logic [PW-1:0] booth_pp(input logic [2:0] trip, input logic [PW-1:0] a_wide);
      logic [PW-1:0] mag;
      logic          neg;
      case (trip)
         3'b001, 3'b010: begin mag = a_wide;        neg = 1'b0; end
         3'b011:         begin mag = a_wide << 1;   neg = 1'b0; end
         3'b100:         begin mag = a_wide << 1;   neg = 1'b1; end
         3'b101, 3'b110: begin mag = a_wide;        neg = 1'b1; end
         default:        begin mag = {PW{1'b0}};    neg = 1'b0; end
      endcase
      return neg ? (~mag + {{(PW-1){1'b0}}, 1'b1}) : mag;
   endfunction

   logic [XLEN-1:0]   op_src1_s;
   logic [XLEN-1:0]   op_src2_s;
   logic              op_a_signed_s;
   logic              op_b_signed_s;
   logic              op_mulw_s;
   logic              op_sel_hi_s;
   logic              load_out_s;
   logic              accept_s;
   logic              out_can_accept_s;

   logic [AW-1:0]     a_ext_s;
   logic [AW-1:0]     b_ext_s;
   logic [AW:0]       b_pad_s;
   logic [PW-1:0]     a_wide_s;
   logic [PW-1:0]     pp_s [NPP];
   logic [PW*NPP-1:0] cols_s;

   logic              out_valid_r;
   logic [PW*NPP-1:0] pp_cols_r;
   logic              out_sel_hi_r;
   logic              out_mulw_r;

   assign out_can_accept_s = !out_valid_r || bus.out_ready;

`ifdef YSYX_040066_BOOTH_IN_REG_EN
   logic              in_valid_r;
   logic [XLEN-1:0]   src1_r;
   logic [XLEN-1:0]   src2_r;
   logic              a_signed_r;
   logic              b_signed_r;
   logic              mulw_r;
   logic              sel_hi_r;

   assign bus.in_ready = !bus.flush && (!in_valid_r || out_can_accept_s);
   assign accept_s     = bus.in_valid && bus.in_ready;
   assign load_out_s   = !bus.flush && in_valid_r && out_can_accept_s;

   assign op_src1_s     = src1_r;
   assign op_src2_s     = src2_r;
   assign op_a_signed_s = a_signed_r;
   assign op_b_signed_s = b_signed_r;
   assign op_mulw_s     = mulw_r;
   assign op_sel_hi_s   = sel_hi_r;

   // Operand capture stage; empties when its contents move to the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_valid_r <= 1'b0;
         src1_r     <= {XLEN{1'b0}};
         src2_r     <= {XLEN{1'b0}};
         a_signed_r <= 1'b0;
         b_signed_r <= 1'b0;
         mulw_r     <= 1'b0;
         sel_hi_r   <= 1'b0;
      end else if (bus.flush) begin
         in_valid_r <= 1'b0;
      end else if (accept_s) begin
         in_valid_r <= 1'b1;
         src1_r     <= bus.src1;
         src2_r     <= bus.src2;
         a_signed_r <= bus.a_signed;
         b_signed_r <= bus.b_signed;
         mulw_r     <= bus.mulw;
         sel_hi_r   <= bus.sel_hi;
      end else if (load_out_s) begin
         in_valid_r <= 1'b0;
      end else begin
         in_valid_r <= in_valid_r;
      end
   end
`else
   assign bus.in_ready = !bus.flush && out_can_accept_s;
   assign accept_s     = bus.in_valid && bus.in_ready;
   assign load_out_s   = accept_s;

   assign op_src1_s     = bus.src1;
   assign op_src2_s     = bus.src2;
   assign op_a_signed_s = bus.a_signed;
   assign op_b_signed_s = bus.b_signed;
   assign op_mulw_s     = bus.mulw;
   assign op_sel_hi_s   = bus.sel_hi;
`endif

   // Operand extension to 66 bits; MULW forces sign-extension of the low word.
   always_comb begin
      if (op_mulw_s) begin
         a_ext_s = {{(AW-32){op_src1_s[31]}}, op_src1_s[31:0]};
         b_ext_s = {{(AW-32){op_src2_s[31]}}, op_src2_s[31:0]};
      end else begin
         a_ext_s = {{2{op_a_signed_s & op_src1_s[XLEN-1]}}, op_src1_s};
         b_ext_s = {{2{op_b_signed_s & op_src2_s[XLEN-1]}}, op_src2_s};
      end
      b_pad_s  = {b_ext_s, 1'b0};
      a_wide_s = {{(PW-AW){a_ext_s[AW-1]}}, a_ext_s};
   end

   // Partial products and their transpose: bit k of column j is bit j of pp_k.
   always_comb begin
      cols_s = {(PW*NPP){1'b0}};
      for (int i = 0; i < NPP; i++) begin
         pp_s[i] = booth_pp(b_pad_s[2*i+2 -: 3], a_wide_s) << (2 * i);
      end
      for (int j = 0; j < PW; j++) begin
         for (int k = 0; k < NPP; k++) begin
            cols_s[j*NPP + k] = pp_s[k][j];
         end
      end
   end

   // Output register: loads only on a new result, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         pp_cols_r    <= {(PW*NPP){1'b0}};
         out_sel_hi_r <= 1'b0;
         out_mulw_r   <= 1'b0;
      end else if (bus.flush) begin
         out_valid_r  <= 1'b0;
      end else if (load_out_s) begin
         out_valid_r  <= 1'b1;
         pp_cols_r    <= cols_s;
         out_sel_hi_r <= op_sel_hi_s;
         out_mulw_r   <= op_mulw_s;
      end else if (bus.out_ready) begin
         out_valid_r  <= 1'b0;
      end else begin
         out_valid_r  <= out_valid_r;
      end
   end

   assign bus.out_valid  = out_valid_r;
   assign bus.pp_cols    = pp_cols_r;
   assign bus.out_sel_hi = out_sel_hi_r;
   assign bus.out_mulw   = out_mulw_r;
endmodule
